// File: rtl/nes_button_decoder.sv
// NES controller serial decoder: samples the 8-bit button frame produced by an
// upstream latch/pulse generator, commits the held state once per frame and
// generates per-button action pulses, with auto-repeat on Down/Left/Right.
module nes_button_decoder #(
    parameter int unsigned DAS_FRAMES = 16,
    parameter int unsigned ARR_FRAMES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       latch,
    input  logic       pulse,
    input  logic       button_data,
    output logic [7:0] buttons,
    output logic [7:0] press,
    output logic       frame_valid,
    output logic       frame_error
);

    localparam int unsigned NUM_BTN = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned REP_LO  = 5;  // Down, Left, Right occupy [7:5]
    localparam int unsigned NUM_REP = 3;
    localparam int unsigned NON_REP = 5;  // A, B, Select, Start, Up occupy [4:0]

    localparam logic [CNT_W-1:0] DAS_C    = CNT_W'(DAS_FRAMES);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(DAS_FRAMES - ARR_FRAMES);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BTN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        SHIFT   = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t               state;
    logic [BIT_W-1:0]     count;
    logic [NUM_BTN-1:0]   shift_reg;
    logic [CNT_W-1:0]     rep_cnt [NUM_REP];

    logic                 data_meta;
    logic                 data_sync;
    logic                 latch_cur;
    logic                 latch_prev;
    logic                 pulse_cur;
    logic                 pulse_prev;

    logic                 latch_rise;
    logic                 latch_fall;
    logic                 pulse_fall;

    logic [NUM_BTN-1:0]   new_btn;
    logic [NUM_BTN-1:0]   press_c;
    logic [CNT_W-1:0]     rep_cnt_c [NUM_REP];
    logic [CNT_W-1:0]     inc;

    // Synchronize pad data and register the strobes for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_meta  <= 1'b0;
            data_sync  <= 1'b0;
            latch_cur  <= 1'b0;
            latch_prev <= 1'b0;
            pulse_cur  <= 1'b0;
            pulse_prev <= 1'b0;
        end else begin
            data_meta  <= button_data;
            data_sync  <= data_meta;
            latch_cur  <= latch;
            latch_prev <= latch_cur;
            pulse_cur  <= pulse;
            pulse_prev <= pulse_cur;
        end
    end

    assign latch_rise = ~latch_prev & latch_cur;
    assign latch_fall = latch_prev & ~latch_cur;
    assign pulse_fall = pulse_prev & ~pulse_cur;

    // Action pulses and repeat-counter updates for the frame being committed
    always_comb begin
        new_btn   = ~shift_reg;
        press_c   = '0;
        inc       = '0;
        for (int r = 0; r < NUM_REP; r++) begin
            rep_cnt_c[r] = rep_cnt[r];
        end
        press_c[NON_REP-1:0] = new_btn[NON_REP-1:0] & ~buttons[NON_REP-1:0];
        for (int r = 0; r < NUM_REP; r++) begin
            inc = rep_cnt[r] + CNT_W'(1);
            if (new_btn[REP_LO + r] && !buttons[REP_LO + r]) begin
                press_c[REP_LO + r] = 1'b1;
                rep_cnt_c[r]        = '0;
            end else if (new_btn[REP_LO + r] && buttons[REP_LO + r]) begin
                if (inc == DAS_C) begin
                    press_c[REP_LO + r] = 1'b1;
                    rep_cnt_c[r]        = RELOAD_C;
                end else begin
                    rep_cnt_c[r] = inc;
                end
            end else begin
                rep_cnt_c[r] = '0;
            end
        end
    end

    // Frame capture FSM with registered outputs; latch edges outrank pulse falls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            shift_reg   <= '0;
            buttons     <= '0;
            press       <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            for (int r = 0; r < NUM_REP; r++) begin
                rep_cnt[r] <= '0;
            end
        end else begin
            press       <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (latch_rise) begin
                        state <= LATCHED;
                    end
                end
                LATCHED: begin
                    if (latch_fall) begin
                        shift_reg[0] <= data_sync;
                        count        <= BIT_W'(1);
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (latch_rise) begin
                        if (count < BIT_W'(NUM_BTN)) begin
                            frame_error <= 1'b1;
                        end
                        shift_reg <= '0;
                        count     <= '0;
                        state     <= LATCHED;
                    end else if (latch_fall) begin
                        state <= SHIFT;
                    end else if (pulse_fall) begin
                        shift_reg[count[2:0]] <= data_sync;
                        count                 <= count + BIT_W'(1);
                        if (count == LAST_BIT) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    buttons     <= ~shift_reg;
                    press       <= press_c;
                    frame_valid <= 1'b1;
                    for (int r = 0; r < NUM_REP; r++) begin
                        rep_cnt[r] <= rep_cnt_c[r];
                    end
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_button_decoder.sv
// Scoreboard bench for nes_button_decoder: directed frames push their
// hand-computed commit/abort results; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_nes_button_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       latch;
    logic       pulse;
    logic       button_data;
    logic [7:0] buttons;
    logic [7:0] press;
    logic       frame_valid;
    logic       frame_error;

    typedef struct {
        bit         is_err;
        logic [7:0] btn;
        logic [7:0] prs;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fall_cyc = 0;

    nes_button_decoder #(.DAS_FRAMES(16), .ARR_FRAMES(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .latch       (latch),
        .pulse       (pulse),
        .button_data (button_data),
        .buttons     (buttons),
        .press       (press),
        .frame_valid (frame_valid),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every commit or abort pulse consumes one expected entry
    always @(negedge clk) begin
        if (reset && (frame_valid || frame_error)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, frame_error, frame_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_kind", {30'd0, frame_error, frame_valid},
                    e.is_err ? 32'd2 : 32'd1);
                chk("buttons", 32'(buttons), 32'(e.btn));
                chk("press", 32'(press), 32'(e.prs));
                if (frame_valid) begin
                    chk("commit_latency", 32'(cyc - fall_cyc), 32'd3);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send a frame of nbits (1..8); pressed is active-high, pad data active-low
    task automatic send_frame(input logic [7:0] pressed, input int nbits, input bit coincident);
        button_data = ~pressed[0];
        latch = 1'b1;
        if (coincident) pulse = 1'b1;
        wait_cyc(4);
        latch = 1'b0;
        pulse = 1'b0;
        fall_cyc = cyc;
        wait_cyc(4);
        for (int i = 1; i < nbits; i++) begin
            button_data = ~pressed[i];
            wait_cyc(3);
            pulse = 1'b1;
            wait_cyc(3);
            pulse = 1'b0;
            fall_cyc = cyc;
            wait_cyc(3);
        end
        button_data = 1'b1;
        wait_cyc(3);
    endtask

    task automatic push(input bit is_err, input logic [7:0] btn, input logic [7:0] prs);
        exp_t e;
        e.is_err = is_err;
        e.btn    = btn;
        e.prs    = prs;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0] prs;
        reset = 1'b0;
        latch = 1'b0;
        pulse = 1'b0;
        button_data = 1'b1;
        wait_cyc(4);
        chk("reset_outputs", {14'd0, buttons, press, frame_valid, frame_error}, 32'd0);
        reset = 1'b1;
        wait_cyc(4);

        // A + Left held 30 frames: Left repeats at frames 17, 23, 29
        for (int f = 1; f <= 30; f++) begin
            if (f == 1) prs = 8'h41;
            else if (f == 17 || f == 23 || f == 29) prs = 8'h40;
            else prs = 8'h00;
            push(1'b0, 8'h41, prs);
            send_frame(8'h41, 8, 1'b0);
        end

        // Abort after 4 pulse falls, then a normal Start-only frame
        send_frame(8'h00, 5, 1'b0);
        push(1'b1, 8'h41, 8'h00);
        push(1'b0, 8'h08, 8'h08);
        send_frame(8'h08, 8, 1'b0);

        // Left held 20, released 1, held again: repeat restarts from scratch
        for (int f = 1; f <= 20; f++) begin
            prs = (f == 1 || f == 17) ? 8'h40 : 8'h00;
            push(1'b0, 8'h40, prs);
            send_frame(8'h40, 8, 1'b0);
        end
        push(1'b0, 8'h00, 8'h00);
        send_frame(8'h00, 8, 1'b0);
        for (int f = 1; f <= 17; f++) begin
            prs = (f == 1 || f == 17) ? 8'h40 : 8'h00;
            push(1'b0, 8'h40, prs);
            send_frame(8'h40, 8, 1'b0);
        end

        // Latch fall coincident with pulse fall: only bit 0 taken
        push(1'b0, 8'h84, 8'h84);
        send_frame(8'h84, 8, 1'b1);

        // Start held, then reset mid-frame; next frame sees Start as new
        push(1'b0, 8'h08, 8'h08);
        send_frame(8'h08, 8, 1'b0);
        send_frame(8'h08, 5, 1'b0);
        reset = 1'b0;
        wait_cyc(2);
        chk("midframe_reset_outputs", {14'd0, buttons, press, frame_valid, frame_error}, 32'd0);
        reset = 1'b1;
        wait_cyc(4);
        push(1'b0, 8'h08, 8'h08);
        send_frame(8'h08, 8, 1'b0);

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            wait_cyc(1);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nes_button_decoder.md
NES_BUTTON_DECODER -- requirements
Module: nes_button_decoder

Interface
REQ-001 SHALL have parameter DAS_FRAMES, default 16, meaning frames a repeatable button is held before the first auto-repeat.
REQ-002 SHALL have parameter ARR_FRAMES, default 6, meaning frames between subsequent auto-repeats; legal range 1..DAS_FRAMES.
REQ-003 SHALL have port clk  input  1  40 MHz system clock; all flops on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port latch  input  1  controller latch strobe from the upstream latch/pulse generator, synchronous to clk.
REQ-006 SHALL have port pulse  input  1  controller shift clock from the upstream generator, synchronous to clk.
REQ-007 SHALL have port button_data  input  1  serial data from the controller pad, asynchronous, active-low (0 = pressed).
REQ-008 SHALL have port buttons  output  8  debounced held state, active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-009 SHALL have port press  output  8  one-cycle action pulses per button (new press or auto-repeat).
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse when a complete 8-bit frame commits.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse when a frame is aborted before 8 bits.

Function
REQ-012 SHALL pass button_data through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 SHALL register latch and pulse once and detect edges as prev/current: rise = ~prev & cur, fall = prev & ~cur.
REQ-014 SHALL implement states IDLE, LATCHED, SHIFT, COMMIT.
REQ-015 IDLE: on latch rise -> LATCHED; pulse edges ignored.
REQ-016 LATCHED: on latch fall, sample bit 0 (A), set bit count to 1, -> SHIFT.
REQ-017 SHIFT: on each pulse fall, sample the next bit into index = count, count++; when count reaches 8 -> COMMIT.
REQ-018 SHIFT: latch rise with count < 8 -> pulse frame_error for one cycle, discard partial data, -> LATCHED.
REQ-019 Same-cycle latch edge and pulse fall: latch edge has priority; pulse fall is ignored.
REQ-020 COMMIT (exactly one cycle): buttons <= ~shift_reg; frame_valid = 1; press computed; -> IDLE.
REQ-021 Latency: buttons, press and frame_valid SHALL update on the clock edge one cycle after the 8th bit is sampled.
REQ-022 Non-repeatable buttons (A, B, Select, Start, Up): press[i] = 1 at commit iff new[i] & ~old[i].
REQ-023 Repeatable buttons (Down, Left, Right) SHALL each own a 5-bit frame counter, updated only at commit.
REQ-024 Repeatable, new press (~old & new): press[i] = 1, counter <= 0.
REQ-025 Repeatable, held (old & new): counter++; when incremented value equals DAS_FRAMES, press[i] = 1 and counter <= DAS_FRAMES - ARR_FRAMES.
REQ-026 Repeatable, released (~new): counter <= 0; press[i] = 0.
REQ-027 Left and Right both held: both counters run independently; no mutual suppression.
REQ-028 press and frame_valid SHALL be 0 in every cycle other than COMMIT; frame_error SHALL be 0 in every cycle other than an abort.

Reset
REQ-029 While reset = 0: state = IDLE; buttons, press, frame_valid, frame_error, shift_reg, count, all repeat counters, synchronizer flops and edge-detect flops = 0.
REQ-030 Reset deassertion mid-frame SHALL resume in IDLE; the first commit after reset treats old state as all-released.

Verification
REQ-031 Frame with A and Left pressed (serial 0,1,1,1,1,1,0,1) -> buttons = 8'h41, press = 8'h41 for 1 cycle, frame_valid = 1 one cycle after the 8th pulse fall.
REQ-032 Same frame repeated 30 times -> press[0] only on frame 1; press[6] on frames 1, 17, 23, 29.
REQ-033 Latch re-rises after 4 pulse falls -> frame_error = 1 for 1 cycle, buttons unchanged, next full frame commits normally.
REQ-034 Left held 20 frames, released 1 frame, held again -> press[6] on frame 1 of the second hold, counter restarted (next repeat 16 frames later).
REQ-035 Reset asserted after 5 bits with Start held -> all outputs 0; after release, next full frame shows press[3] = 1.
REQ-036 Latch fall coincident with pulse fall -> only bit 0 sampled that cycle; count = 1.
